// File: rtl/rle_comp_unit_p.sv
// Multi-lane run-length compressor: scans up to LANES symbols per word, merging
// equal runs across words until in_last, and emits (symbol, length) pairs.
module rle_comp_unit_p #(
    parameter int LANES = 4,
    parameter int SYM_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANES*SYM_W-1:0]   din,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [SYM_W-1:0]         out_val,
    output logic [CNT_W-1:0]         out_len,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int PTR_W = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] MAX_LEN = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

    state_t                   state_reg, state_next;
    logic [LANES*SYM_W-1:0]   buf_reg, buf_next;
    logic [PTR_W-1:0]         ptr_reg, ptr_next;
    logic                     last_reg, last_next;
    logic [SYM_W-1:0]         pend_val_reg, pend_val_next;
    logic [CNT_W-1:0]         pend_len_reg, pend_len_next;
    logic                     pend_act_reg, pend_act_next;
    logic [SYM_W-1:0]         out_val_reg, out_val_next;
    logic [CNT_W-1:0]         out_len_reg, out_len_next;
    logic                     out_last_reg, out_last_next;
    logic                     out_valid_reg, out_valid_next;

    logic [SYM_W-1:0]         lane [LANES];
    logic [SYM_W-1:0]         seg_val;
    logic [CNT_W-1:0]         seg_len;
    logic                     seg_run;
    logic [CNT_W:0]           seg_sum;
    logic [PTR_W-1:0]         ptr_adv;
    logic                     out_free;
    logic                     advance;
    logic                     emit;
    logic [SYM_W-1:0]         emit_val;
    logic [CNT_W-1:0]         emit_len;
    logic                     emit_last;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane[gi] = buf_reg[gi*SYM_W +: SYM_W];
        end
    endgenerate

    // Segment: symbol at the pointer and how many following lanes repeat it.
    always_comb begin
        seg_val = lane[0];
        seg_len = '0;
        seg_run = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (ptr_reg == PTR_W'(i)) seg_val = lane[i];
        end
        for (int i = 0; i < LANES; i++) begin
            if (PTR_W'(i) >= ptr_reg) begin
                if (seg_run && lane[i] == seg_val) seg_len = seg_len + CNT_W'(1);
                else seg_run = 1'b0;
            end
        end
    end

    assign seg_sum  = {1'b0, pend_len_reg} + {1'b0, seg_len};
    assign ptr_adv  = ptr_reg + PTR_W'(seg_len);
    assign out_free = !out_valid_reg || out_ready;
    assign in_ready = (state_reg == IDLE) && reset;

    always_comb begin
        state_next    = state_reg;
        buf_next      = buf_reg;
        ptr_next      = ptr_reg;
        last_next     = last_reg;
        pend_val_next = pend_val_reg;
        pend_len_next = pend_len_reg;
        pend_act_next = pend_act_reg;
        advance       = 1'b0;
        emit          = 1'b0;
        emit_val      = pend_val_reg;
        emit_len      = pend_len_reg;
        emit_last     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready) begin
                    buf_next   = din;
                    ptr_next   = '0;
                    last_next  = in_last;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (!pend_act_reg) begin
                    pend_act_next = 1'b1;
                    pend_val_next = seg_val;
                    pend_len_next = seg_len;
                    advance       = 1'b1;
                end else if (pend_val_reg == seg_val) begin
                    if (seg_sum <= {1'b0, MAX_LEN}) begin
                        pend_len_next = seg_sum[CNT_W-1:0];
                        advance       = 1'b1;
                    end else if (out_free) begin
                        emit          = 1'b1;
                        emit_len      = MAX_LEN;
                        pend_len_next = CNT_W'(seg_sum - {1'b0, MAX_LEN});
                        advance       = 1'b1;
                    end
                end else if (out_free) begin
                    emit          = 1'b1;
                    pend_val_next = seg_val;
                    pend_len_next = seg_len;
                    advance       = 1'b1;
                end
                if (advance) begin
                    ptr_next = ptr_adv;
                    if (ptr_adv == PTR_W'(LANES)) state_next = last_reg ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    emit          = 1'b1;
                    emit_last     = 1'b1;
                    pend_act_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        out_val_next   = out_val_reg;
        out_len_next   = out_len_reg;
        out_last_next  = out_last_reg;
        out_valid_next = out_valid_reg;
        if (emit) begin
            out_val_next   = emit_val;
            out_len_next   = emit_len;
            out_last_next  = emit_last;
            out_valid_next = 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            buf_reg       <= '0;
            ptr_reg       <= '0;
            last_reg      <= 1'b0;
            pend_val_reg  <= '0;
            pend_len_reg  <= '0;
            pend_act_reg  <= 1'b0;
            out_val_reg   <= '0;
            out_len_reg   <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            buf_reg       <= buf_next;
            ptr_reg       <= ptr_next;
            last_reg      <= last_next;
            pend_val_reg  <= pend_val_next;
            pend_len_reg  <= pend_len_next;
            pend_act_reg  <= pend_act_next;
            out_val_reg   <= out_val_next;
            out_len_reg   <= out_len_next;
            out_last_reg  <= out_last_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_val   = out_val_reg;
    assign out_len   = out_len_reg;
    assign out_last  = out_last_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_rle_comp_unit_p.sv
// Bench for rle_comp_unit_p: directed and random streams scored against a
// symbol-level run-length model; a second instance exercises a 3-bit counter.
module tb_rle_comp_unit_p;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        in_valid, in_last, in_ready;
    logic [7:0]  out_val, out_len;
    logic        out_last, out_valid, out_ready;

    logic [31:0] b_din;
    logic        b_in_valid, b_in_last, b_in_ready;
    logic [7:0]  b_out_val;
    logic [2:0]  b_out_len;
    logic        b_out_last, b_out_valid, b_out_ready;

    rle_comp_unit_p #(.LANES(4), .SYM_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .din(din), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_val(out_val), .out_len(out_len), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    rle_comp_unit_p #(.LANES(4), .SYM_W(8), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .din(b_din), .in_valid(b_in_valid), .in_last(b_in_last),
        .in_ready(b_in_ready), .out_val(b_out_val), .out_len(b_out_len), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [16:0] exp_q[$];
    logic [16:0] b_got[$];
    logic [31:0] wq[$];
    logic [7:0]  sq[$];
    bit          acc;
    bit          hold_prev = 1'b0;
    logic [16:0] prev_pair;
    bit          rand_ready = 1'b0;

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) b_got.push_back({b_out_val, 5'b0, b_out_len, b_out_last});
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: split the symbol stream sq into maximal runs, cut each into
    // chunks of at most maxl; only the very last chunk carries last=1.
    task automatic model_stream(input int maxl);
        int i, j, n, len;
        i = 0;
        n = sq.size();
        while (i < n) begin
            j = i;
            while (j < n && sq[j] == sq[i]) j++;
            len = j - i;
            while (len > maxl) begin
                exp_q.push_back({sq[i], 8'(maxl), 1'b0});
                len -= maxl;
            end
            exp_q.push_back({sq[i], 8'(len), (j == n)});
            i = j;
        end
    endtask

    task automatic words_to_syms();
        sq.delete();
        foreach (wq[w]) for (int l = 0; l < 4; l++) sq.push_back(wq[w][l*8 +: 8]);
    endtask

    task automatic tick();
        @(negedge clk);
        if (hold_prev) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_pair", 32'({out_val, out_len, out_last}), 32'(prev_pair));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("pair_expected", 0, 1);
            else chk("pair", 32'({out_val, out_len, out_last}), 32'(exp_q.pop_front()));
        end
        hold_prev = out_valid && !out_ready && reset;
        prev_pair = {out_val, out_len, out_last};
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        int n;
        din = w;
        in_last = last;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            tick();
            n++;
        end
        chk("accept", 32'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic send_stream();
        words_to_syms();
        model_stream(255);
        foreach (wq[w]) send_word(wq[w], w == wq.size() - 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (6) tick();
    endtask

    initial begin
        int n;
        bit got;
        logic [7:0] s;
        logic [31:0] word;

        reset = 1'b0;
        din = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        b_din = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_val", 32'(out_val), 0);
        chk("rst_out_len", 32'(out_len), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 1);
        @(posedge clk); #1;

        // 3-bit counter instance: twelve 0x55 symbols split at MAX=7
        wq.delete();
        repeat (3) wq.push_back(32'h55555555);
        words_to_syms();
        model_stream(7);
        for (int w = 0; w < 3; w++) begin
            b_din = wq[w];
            b_in_last = (w == 2);
            b_in_valid = 1'b1;
            n = 0;
            got = 1'b0;
            while (!got && n < 100) begin
                @(negedge clk);
                got = b_in_ready;
                @(posedge clk); #1;
                n++;
            end
            chk("b_accept", 32'(got), 1);
            b_in_valid = 1'b0;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("b_count", b_got.size(), exp_q.size());
        while (exp_q.size() > 0 && b_got.size() > 0) chk("b_pair", 32'(b_got.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();

        // merge across words, split at in_last
        wq.delete(); wq.push_back(32'h41414141); send_word(wq[0], 1'b0);
        words_to_syms(); sq.push_back(8'h41); sq.push_back(8'h41); sq.push_back(8'h41); sq.push_back(8'h42);
        model_stream(255);
        send_word(32'h42414141, 1'b1);
        drain();

        wq.delete(); wq.push_back(32'h44332211); send_stream(); drain();

        // identical single-word streams must not merge
        wq.delete(); wq.push_back(32'h66666666); send_stream(); send_stream(); drain();

        // backpressure: first pair held for 10 cycles
        out_ready = 1'b0;
        wq.delete(); wq.push_back(32'h44332211); send_stream();
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        chk("bp_valid", 32'(out_valid), 1);
        repeat (10) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        drain();

        // abort mid-stream with a reset pulse
        send_word(32'h41414141, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_out_len", 32'(out_len), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        hold_prev = 1'b0;
        wq.delete(); wq.push_back(32'h42424242); send_stream(); drain();

        // 280 equal symbols: one MAX chunk then remainder
        wq.delete();
        repeat (70) wq.push_back(32'h77777777);
        send_stream(); drain();

        // random streams with random backpressure
        rand_ready = 1'b1;
        s = 8'hA0;
        for (int st = 0; st < 30; st++) begin
            wq.delete();
            n = $urandom_range(1, 4);
            for (int w = 0; w < n; w++) begin
                word = '0;
                for (int l = 0; l < 4; l++) begin
                    if ($urandom_range(0, 1) == 1) s = 8'hA0 + 8'($urandom_range(0, 2));
                    word[l*8 +: 8] = s;
                end
                wq.push_back(word);
            end
            send_stream();
        end
        drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
